// File: rtl/exec_stage.sv
// Execute stage between register-file read ports and its write port.
// Single-cycle ALU ops complete in one cycle. Shifts and rotates run
// bit-serially, one position per cycle. Result and flags are registered
// and held until the next operation completes.
module exec_stage #(
  parameter int unsigned W  = 8,
  parameter int unsigned SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [W-1:0]  dat_a,
  input  logic [W-1:0]  dat_b,
  output logic          busy,
  output logic          wr_en,
  output logic [W-1:0]  dat_out,
  output logic          zero,
  output logic          carry
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_ROL  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  state_e         state_q;
  op_e            op_q;
  op_e            op_in;
  logic [W-1:0]   acc_q;
  logic [SW-1:0]  cnt_q;
  logic [W-1:0]   dat_out_q;
  logic           busy_q, wr_en_q, zero_q, carry_q;

  logic [SW-1:0]  k;
  logic           is_shift;
  logic [W:0]     arith;
  logic [W-1:0]   alu_res, step_res;
  logic           alu_c, step_c;

  // Single-cycle result from the live inputs (also covers shift by zero).
  always_comb begin
    op_in    = op_e'(op);
    k        = dat_b[SW-1:0];
    is_shift = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_ROL);
    arith    = '0;
    alu_res  = dat_a;
    alu_c    = 1'b0;
    case (op_in)
      OP_ADD: begin
        arith   = {1'b0, dat_a} + {1'b0, dat_b};
        alu_res = arith[W-1:0];
        alu_c   = arith[W];
      end
      OP_SUB: begin
        // Borrow out of the extended difference is the inverse of a >= b.
        arith   = {1'b0, dat_a} - {1'b0, dat_b};
        alu_res = arith[W-1:0];
        alu_c   = ~arith[W];
      end
      OP_AND:  alu_res = dat_a & dat_b;
      OP_XOR:  alu_res = dat_a ^ dat_b;
      OP_PASS: alu_res = dat_b;
      default: alu_res = dat_a;
    endcase
  end

  // One-position shift/rotate of the accumulator for the latched opcode.
  always_comb begin
    case (op_q)
      OP_SLL: begin
        step_res = {acc_q[W-2:0], 1'b0};
        step_c   = acc_q[W-1];
      end
      OP_SRL: begin
        step_res = {1'b0, acc_q[W-1:1]};
        step_c   = acc_q[0];
      end
      default: begin
        step_res = {acc_q[W-2:0], acc_q[W-1]};
        step_c   = acc_q[W-1];
      end
    endcase
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      acc_q     <= '0;
      cnt_q     <= '0;
      dat_out_q <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (is_shift && (k != '0)) begin
              acc_q   <= dat_a;
              cnt_q   <= k;
              op_q    <= op_in;
              state_q <= S_SHIFT;
            end else begin
              dat_out_q <= alu_res;
              zero_q    <= (alu_res == '0);
              carry_q   <= alu_c;
              wr_en_q   <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          acc_q <= step_res;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SW'(1)) begin
            dat_out_q <= step_res;
            zero_q    <= (step_res == '0);
            carry_q   <= step_c;
            wr_en_q   <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign dat_out = dat_out_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed vectors with literal expectations, plus
// an arithmetic reference model compared against the DUT every cycle.
module tb_exec_stage;

  localparam int unsigned W    = 8;
  localparam int unsigned SW   = 3;
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op    = 3'd0;
  logic [W-1:0]  dat_a = '0;
  logic [W-1:0]  dat_b = '0;
  logic          busy, wr_en, zero, carry;
  logic [W-1:0]  dat_out;

  int total = 0;
  int bad   = 0;

  exec_stage #(.W(W), .SW(SW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .dat_a   (dat_a),
    .dat_b   (dat_b),
    .busy    (busy),
    .wr_en   (wr_en),
    .dat_out (dat_out),
    .zero    (zero),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Whole-operation reference: result, flag and latency in one step.
  function automatic void model_op(input int unsigned o, input int unsigned a,
                                   input int unsigned b, output int unsigned res,
                                   output int unsigned c, output int unsigned lat);
    int unsigned kk;
    kk  = b % (1 << SW);
    lat = 1;
    c   = 0;
    case (o)
      0: begin res = (a + b) & MASK; c = ((a + b) >> W) & 1; end
      1: begin res = (a - b) & MASK; c = (a >= b) ? 1 : 0; end
      2: res = a & b;
      3: res = a ^ b;
      4: begin
        res = (a << kk) & MASK;
        if (kk > 0) c = (a >> (W - kk)) & 1;
      end
      5: begin
        res = a >> kk;
        if (kk > 0) c = (a >> (kk - 1)) & 1;
      end
      6: begin
        res = ((a << kk) | (a >> (W - kk))) & MASK;
        if (kk > 0) c = res & 1;
      end
      default: res = b;
    endcase
    if (o >= 4 && o <= 6 && kk > 0) lat = kk + 1;
  endfunction

  int unsigned  m_left = 0;
  int unsigned  p_out = 0, p_c = 0, p_lat = 0;
  logic [W-1:0] m_out   = '0;
  logic         m_zero  = 1'b0;
  logic         m_carry = 1'b0;

  // Model: m_left counts busy cycles still to run, write is the last one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  = 0;
      m_out   = '0;
      m_zero  = 1'b0;
      m_carry = 1'b0;
    end else begin
      if (m_left > 0) m_left--;
      else if (start) begin
        model_op(op, dat_a, dat_b, p_out, p_c, p_lat);
        m_left = p_lat;
      end
      if (m_left == 1) begin
        m_out   = p_out[W-1:0];
        m_zero  = (p_out == 0);
        m_carry = p_c[0];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("cyc busy",    busy,    m_left > 0);
    check("cyc wr_en",   wr_en,   m_left == 1);
    check("cyc dat_out", dat_out, m_out);
    check("cyc zero",    zero,    m_zero);
    check("cyc carry",   carry,   m_carry);
  end

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_out,
                     input logic exp_z, input logic exp_c, input int exp_lat);
    int cyc;
    @(negedge clk);
    op = o; dat_a = a; dat_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dat_a = W'($urandom);
    dat_b = W'($urandom);
    cyc = 1;
    while (wr_en !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, exp_lat);
    check({name, " dat_out"}, dat_out, exp_out);
    check({name, " zero"}, zero, exp_z);
    check({name, " carry"}, carry, exp_c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pmap;
    int nwr;
    #3;
    check("reset busy", busy, 1'b0);
    check("reset wr_en", wr_en, 1'b0);
    check("reset dat_out", dat_out, 8'h00);
    check("reset flags", {zero, carry}, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("add ovf", 3'b000, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1);

    // Asynchronous reset in mid-cycle clears the held result at once.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst dat_out", dat_out, 8'h00);
    check("async rst flags", {zero, carry}, 2'b00);
    check("async rst busy", {busy, wr_en}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort a SLL by 5 from inside SHIFT.
    @(negedge clk);
    op = 3'b100; dat_a = 8'h81; dat_b = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort busy before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort busy after", {busy, wr_en}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0;
    repeat (8) begin
      @(negedge clk);
      if (wr_en) nwr++;
    end
    check("abort no write", nwr, 0);

    run("sub eq",   3'b001, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1);
    run("sub brw",  3'b001, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1);
    run("and",      3'b010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1);
    run("xor",      3'b011, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1);
    run("sll3",     3'b100, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 4);
    run("rol1",     3'b110, 8'h81, 8'h01, 8'h03, 1'b0, 1'b1, 2);
    run("srl1",     3'b101, 8'h01, 8'hF9, 8'h00, 1'b1, 1'b1, 2);
    run("sll0",     3'b100, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1);
    run("pass",     3'b111, 8'h11, 8'h7E, 8'h7E, 1'b0, 1'b0, 1);
    run("rol7",     3'b110, 8'h96, 8'h07, 8'h4B, 1'b0, 1'b1, 8);
    run("sll7",     3'b100, 8'h01, 8'h07, 8'h80, 1'b0, 1'b0, 8);

    // SRL by 7 with ADD requests held on every busy cycle and beyond.
    @(negedge clk);
    op = 3'b101; dat_a = 8'hC0; dat_b = 8'h07; start = 1'b1;
    @(negedge clk);
    op = 3'b000; dat_a = 8'h01; dat_b = 8'h02;
    pmap = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (wr_en) begin
        pmap = pmap | (1 << c);
        if (c == 8) begin
          check("ignore srl out", dat_out, 8'h01);
          check("ignore srl carry", carry, 1'b1);
        end
        if (c == 10) check("ignore add out", dat_out, 8'h03);
      end
      if (c == 10) start = 1'b0;
    end
    check("ignore pulse map", pmap, (1 << 8) | (1 << 10));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
